// File: rtl/priority_arbiter.sv
// priority_arbiter: shares one downstream resource among N requesters.
// Each arbitration picks a winner either by fixed priority (highest index wins) or by
// rotating round-robin priority. The grant is held until the owner drops its request,
// pulses done, or the hold limit of MAX_HOLD cycles expires.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   mode       0 = fixed priority, 1 = round-robin (sampled only while arbitrating)
//   req        level-sensitive request vector
//   done       owner release strobe (ignored while idle)
//   gnt        registered one-hot grant
//   gnt_id     index of the granted requester, 0 when no grant
//   gnt_valid  grant active (equals |gnt)
//   timeout    one-cycle pulse when a grant is revoked solely by the hold limit
module priority_arbiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned IDW      = 3,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);

  localparam int unsigned CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e         state_q;
  logic [CW-1:0]  hold_cnt_q;
  logic [IDW-1:0] ptr_q;

  logic [IDW-1:0] win;
  logic           at_limit;
  logic           owner_req;
  logic           release_now;

  // Search starts at ptr (round-robin) or N-1 (fixed) and walks downward with wrap;
  // the first set request wins.
  always_comb begin : sel
    int start;
    int j;
    logic found;
    win   = '0;
    found = 1'b0;
    start = mode ? int'(ptr_q) : int'(N) - 1;
    for (int k = 0; k < int'(N); k++) begin
      j = (start >= k) ? (start - k) : (start + int'(N) - k);
      if (!found && req[j]) begin
        win   = IDW'(j);
        found = 1'b1;
      end
    end
  end

  assign at_limit    = (hold_cnt_q == CW'(MAX_HOLD - 1));
  assign owner_req   = req[gnt_id];
  assign release_now = done || !owner_req || at_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt        <= '0;
      gnt_id     <= '0;
      gnt_valid  <= 1'b0;
      timeout    <= 1'b0;
      hold_cnt_q <= '0;
      ptr_q      <= IDW'(N - 1);
    end else begin
      case (state_q)
        StIdle: begin
          timeout <= 1'b0;
          if (|req) begin
            gnt        <= {{(N-1){1'b0}}, 1'b1} << win;
            gnt_id     <= win;
            gnt_valid  <= 1'b1;
            hold_cnt_q <= '0;
            state_q    <= StGrant;
          end
        end
        StGrant: begin
          // An unknown owner request resolves to "keep holding", so outputs stay known.
          if (release_now) begin
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            state_q   <= StIdle;
            ptr_q     <= (gnt_id == '0) ? IDW'(N - 1) : gnt_id - 1'b1;
            // A coincident done or dropped request makes this a normal release.
            if (done || !owner_req) begin
              timeout <= 1'b0;
            end else begin
              timeout <= at_limit;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
            timeout    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_arbiter.sv
module tb_priority_arbiter;

  localparam int N        = 8;
  localparam int IDW      = 3;
  localparam int MAX_HOLD = 15;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           mode = 1'b0;
  logic [N-1:0]   req = '0;
  logic           done = 1'b0;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;
  logic           timeout;

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = none), cycles the grant has been visible,
  // round-robin start index, expected timeout pulse.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = N - 1;
  bit m_to    = 1'b0;

  priority_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    int start;
    int idx;
    if (rst) begin
      m_owner = -1;
      m_held  = 0;
      m_ptr   = N - 1;
      m_to    = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      if (req != '0) begin
        start = mode ? m_ptr : N - 1;
        for (int k = 0; k < N; k++) begin
          idx = (start - k + N) % N;
          if (m_owner < 0 && req[idx]) m_owner = idx;
        end
        m_held = 1;
      end
    end else begin
      if (done || !req[m_owner] || m_held == MAX_HOLD) begin
        m_to    = !done && req[m_owner] && (m_held == MAX_HOLD);
        m_ptr   = (m_owner + N - 1) % N;
        m_owner = -1;
      end else begin
        m_held++;
        m_to = 1'b0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".id"}, 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk({tag, ".valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
    chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
  endtask

  task automatic step(input string tag, input logic r, input logic m,
                      input logic [N-1:0] q, input logic d);
    rst  = r;
    mode = m;
    req  = q;
    done = d;
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin : stim
    int seq[9];
    int vcnt;
    int tcnt;
    logic [N-1:0] rq;
    logic rm;

    // Reset
    step("rst0", 1'b1, 1'b0, 8'h00, 1'b0);
    step("rst1", 1'b1, 1'b0, 8'hFF, 1'b1);
    chk("rst.valid", 32'(gnt_valid), 32'd0);

    // Fixed priority: highest index wins, 1-cycle latency
    step("s1", 1'b0, 1'b0, 8'b0010_0110, 1'b0);
    chk("s1.gnt", 32'(gnt), 32'h20);
    chk("s1.id", 32'(gnt_id), 32'd5);
    step("s2.hold", 1'b0, 1'b0, 8'b0010_0110, 1'b0);
    step("s2.done", 1'b0, 1'b0, 8'b0010_0110, 1'b1);
    chk("s2.dead", 32'(gnt), 32'h0);
    step("s2.regrant", 1'b0, 1'b0, 8'b0010_0110, 1'b0);
    chk("s2.id", 32'(gnt_id), 32'd5);
    step("s2.drop", 1'b0, 1'b0, 8'h00, 1'b0);

    // Round-robin rotation over all requesters
    step("s3.rst", 1'b1, 1'b1, 8'h00, 1'b0);
    for (int g = 0; g < 9; g++) begin
      step("s3.g", 1'b0, 1'b1, 8'hFF, 1'b0);
      seq[g] = int'(gnt_id);
      step("s3.h", 1'b0, 1'b1, 8'hFF, 1'b0);
      step("s3.d", 1'b0, 1'b1, 8'hFF, 1'b1);
    end
    for (int g = 0; g < 9; g++) chk("s3.seq", 32'(seq[g]), (g == 8) ? 32'd7 : 32'(7 - g));

    // Wrap-around search from ptr=2
    step("s4.rst", 1'b1, 1'b1, 8'h00, 1'b0);
    step("s4.g3", 1'b0, 1'b1, 8'b0000_1000, 1'b0);
    chk("s4.id3", 32'(gnt_id), 32'd3);
    step("s4.d3", 1'b0, 1'b1, 8'b0000_1000, 1'b1);
    step("s4.g7", 1'b0, 1'b1, 8'b1000_1000, 1'b0);
    chk("s4.id7", 32'(gnt_id), 32'd7);
    step("s4.d7", 1'b0, 1'b1, 8'b1000_1000, 1'b1);
    step("s4.g3b", 1'b0, 1'b1, 8'b1000_1000, 1'b0);
    chk("s4.id3b", 32'(gnt_id), 32'd3);
    step("s4.d3b", 1'b0, 1'b1, 8'h00, 1'b0);

    // Hold limit with a single held request
    vcnt = 0;
    tcnt = 0;
    for (int c = 0; c < 16; c++) begin
      step("s5.h", 1'b0, 1'b0, 8'h10, 1'b0);
      vcnt += int'(gnt_valid);
      tcnt += int'(timeout);
    end
    chk("s5.valid_cycles", 32'(vcnt), 32'd15);
    chk("s5.timeouts", 32'(tcnt), 32'd1);
    step("s5.regrant", 1'b0, 1'b0, 8'h10, 1'b0);
    chk("s5.id", 32'(gnt_id), 32'd4);

    // done coinciding with the hold limit is a normal release
    for (int c = 0; c < 14; c++) step("s5b.h", 1'b0, 1'b0, 8'h10, 1'b0);
    chk("s5b.still", 32'(gnt_valid), 32'd1);
    step("s5b.done", 1'b0, 1'b0, 8'h10, 1'b1);
    chk("s5b.valid", 32'(gnt_valid), 32'd0);
    chk("s5b.timeout", 32'(timeout), 32'd0);

    // Reset mid-grant restores ptr
    step("s6.g6", 1'b0, 1'b0, 8'h40, 1'b0);
    chk("s6.id6", 32'(gnt_id), 32'd6);
    step("s6.rst", 1'b1, 1'b0, 8'hFF, 1'b1);
    chk("s6.gnt", 32'(gnt), 32'h0);
    chk("s6.id", 32'(gnt_id), 32'd0);
    step("s6.g7", 1'b0, 1'b1, 8'hFF, 1'b0);
    chk("s6.id7", 32'(gnt_id), 32'd7);

    // Randomized traffic against the model
    rq = 8'hFF;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) rq = N'($urandom);
      rm = 1'($urandom);
      step("rnd", ($urandom_range(199) == 0), rm, rq, ($urandom_range(7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
